sd_spi_block_reader: RTL and testbench
======================================

SD_SPI_BLOCK_READER -- requirements
Module: sd_spi_block_reader

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SPI clock half-period (legal 2..255).
REQ-002 Parameter NCR_MAX, default 16: maximum 0xFF bytes clocked while waiting for the R1 response.
REQ-003 Parameter TOKEN_MAX, default 1024: maximum bytes clocked while waiting for the data token.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 rd_req  in  1  single-cycle pulse requesting one 512-byte sector read.
REQ-007 rd_lba  in  32  sector number, sampled in the rd_req accept cycle.
REQ-008 sdhc  in  1  1 = block addressing; 0 = byte addressing; sampled with rd_lba.
REQ-009 busy  out  1  high from the cycle after accept until the cycle done pulses.
REQ-010 done  out  1  one-cycle pulse at the end of every accepted transaction.
REQ-011 err  out  1  transaction-failed flag; valid from done until the next accept.
REQ-012 err_code  out  2  0 none, 1 R1 timeout, 2 R1 nonzero, 3 token timeout or error token.
REQ-013 data_out  out  8  received sector byte; valid while data_valid is high.
REQ-014 data_valid  out  1  one-cycle strobe per sector byte, 512 per successful read.
REQ-015 sd_cs  out  1  card select, active low.
REQ-016 sd_sck  out  1  SPI clock, idle low.
REQ-017 sd_sdi  out  1  master-to-card data; idles high.
REQ-018 sd_sdo  in  1  card-to-master data.

Function
REQ-019 SPI mode 0, MSB first: sd_sdi changes only while sd_sck is low; sd_sdo is sampled in the clk cycle in which sd_sck rises.
REQ-020 Each sd_sck half-period is exactly CLK_DIV clk cycles; each byte is exactly 16*CLK_DIV cycles, with no gaps between bytes of one transaction.
REQ-021 States: IDLE, CMD, RESP, TOKEN, DATA, CRC, TAIL, DONE.
REQ-022 IDLE: sd_cs=1, sd_sck=0, sd_sdi=1; rd_req accepted only here; rd_req in any other state is ignored.
REQ-023 On accept: latch address A = sdhc ? rd_lba : {rd_lba[22:0],9'b0}; drive sd_cs low; go to CMD; first sd_sck rise no earlier than CLK_DIV cycles after sd_cs falls.
REQ-024 CMD transmits 6 bytes: 0x51, A[31:24], A[23:16], A[15:8], A[7:0], 0xFF; then go to RESP.
REQ-025 RESP transmits 0xFF bytes. Received 0xFF means wait.
REQ-026 RESP, first non-0xFF byte 0x00: go to TOKEN.
REQ-027 RESP, first non-0xFF byte nonzero: err_code=2, go to TAIL.
REQ-028 RESP, NCR_MAX bytes all 0xFF: err_code=1, go to TAIL.
REQ-029 TOKEN transmits 0xFF bytes.
REQ-030 TOKEN, byte 0xFE: go to DATA.
REQ-031 TOKEN, byte 0xFF: keep waiting.
REQ-032 TOKEN, any other byte, or TOKEN_MAX bytes without 0xFE: err_code=3, go to TAIL.
REQ-033 DATA clocks 512 bytes with a 9-bit counter; after each eighth sample, data_out gets the byte and data_valid pulses within 2 clk cycles.
REQ-034 DATA counter wraps 511->0 and the state goes to CRC; the CRC bytes are never presented on data_out.
REQ-035 CRC clocks 2 bytes and discards them.
REQ-036 TAIL clocks one 0xFF byte with sd_cs low, then raises sd_cs and goes to DONE.
REQ-037 DONE: done=1 for one cycle, err=(err_code!=0), busy=0; next cycle is IDLE.
REQ-038 A rd_req coinciding with done is ignored.
REQ-039 data_valid never asserts outside DATA, and never on a failed transaction.

Reset
REQ-040 reset_n=0 at any clk edge, including mid-byte or mid-sector, forces next cycle: IDLE, sd_cs=1, sd_sck=0, sd_sdi=1, busy=0, done=0, err=0, err_code=0, data_out=0x00, data_valid=0, all counters 0.
REQ-041 After reset release, the first clk edge may accept rd_req.

Verification
REQ-042 sdhc=1, rd_lba=0x00001234, card model R1=0x00 after 2 0xFF bytes, token after 5 bytes, data i&0xFF -> CMD bytes 51 00 00 12 34 FF; 512 data_valid with values 0..255,0..255; done, err=0.
REQ-043 sdhc=0, rd_lba=0x00000003 -> address bytes 00 00 06 00.
REQ-044 Card never answers (sd_sdo=1) -> after exactly NCR_MAX=16 response bytes, done with err=1, err_code=1, sd_cs high, zero data_valid.
REQ-045 R1=0x04 -> err_code=2; error token 0x08 in TOKEN -> err_code=3; no data_valid in either case.
REQ-046 reset_n low at byte 200 of DATA -> next cycle sd_cs=1, busy=0, no further data_valid; a new rd_req then completes normally.
REQ-047 rd_req pulsed while busy, and again coinciding with done -> both ignored; exactly one transaction; sd_sck period = 2*CLK_DIV throughout.

Source files
------------

// File: rtl/sd_spi_block_reader.sv
// sd_spi_block_reader: SPI-mode SD card single-block (CMD17) reader.
// Streams the 512 sector bytes out on data_out/data_valid and reports R1/token failures.
module sd_spi_block_reader #(
  parameter int CLK_DIV   = 4,
  parameter int NCR_MAX   = 16,
  parameter int TOKEN_MAX = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [31:0] rd_lba,
  input  logic        sdhc,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        sd_cs,
  output logic        sd_sck,
  output logic        sd_sdi,
  input  logic        sd_sdo
);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] NCR_LAST = 16'(NCR_MAX - 1);
  localparam logic [15:0] TOK_LAST = 16'(TOKEN_MAX - 1);
  localparam logic [7:0]  CMD17    = 8'h51;

  typedef enum logic [2:0] {IDLE, CMD, RESP, TOKEN, DATA, CRC, TAIL, DONE} state_t;

  state_t      state_q;
  logic [7:0]  div_q, tx_q, data_out_q;
  logic [6:0]  rx_q;
  logic [2:0]  bit_q;
  logic [15:0] cnt_q;
  logic [31:0] addr_q;
  logic [1:0]  err_code_q;
  logic        sck_q, cs_q, sdi_q, busy_q, done_q, err_q, dv_q;
  logic        active, half_end, rise, fall, byte_end;
  logic [7:0]  rx_d, tx_d;

  assign active   = state_q != IDLE && state_q != DONE;
  assign half_end = active && div_q == DIV_LAST;
  assign rise     = half_end && !sck_q;
  assign fall     = half_end && sck_q;
  assign byte_end = rise && bit_q == 3'd7;
  assign rx_d     = {rx_q, sd_sdo};
  // Next byte to shift out, loaded on the falling edge that closes the previous byte
  assign tx_d = state_q != CMD      ? 8'hFF :
                cnt_q == 16'd1      ? addr_q[31:24] :
                cnt_q == 16'd2      ? addr_q[23:16] :
                cnt_q == 16'd3      ? addr_q[15:8] :
                cnt_q == 16'd4      ? addr_q[7:0] : 8'hFF;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      div_q      <= 8'd0;
      sck_q      <= 1'b0;
      bit_q      <= 3'd0;
      rx_q       <= 7'd0;
      tx_q       <= 8'hFF;
      cnt_q      <= 16'd0;
      addr_q     <= 32'd0;
      cs_q       <= 1'b1;
      sdi_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      data_out_q <= 8'h00;
      dv_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dv_q   <= 1'b0;
      if (active) begin
        div_q <= half_end ? 8'd0 : div_q + 8'd1;
        if (half_end) sck_q <= !sck_q;
      end
      if (rise) begin
        rx_q  <= rx_d[6:0];
        bit_q <= bit_q + 3'd1;
      end
      if (fall && bit_q != 3'd0) begin
        sdi_q <= tx_q[7];
        tx_q  <= {tx_q[6:0], 1'b1};
      end else if (fall && state_q == TAIL && cnt_q == 16'd1) begin
        cs_q    <= 1'b1;
        sdi_q   <= 1'b1;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        err_q   <= err_code_q != 2'd0;
        state_q <= DONE;
      end else if (fall) begin
        sdi_q <= tx_d[7];
        tx_q  <= {tx_d[6:0], 1'b1};
      end
      // Byte-level decisions are taken on the eighth sampling edge
      if (byte_end) begin
        case (state_q)
          CMD: begin
            cnt_q <= cnt_q == 16'd5 ? 16'd0 : cnt_q + 16'd1;
            if (cnt_q == 16'd5) state_q <= RESP;
          end
          RESP:
            if (rx_d == 8'hFF && cnt_q != NCR_LAST) cnt_q <= cnt_q + 16'd1;
            else begin
              cnt_q      <= 16'd0;
              state_q    <= rx_d == 8'h00 ? TOKEN : TAIL;
              err_code_q <= rx_d == 8'hFF ? 2'd1 : rx_d == 8'h00 ? 2'd0 : 2'd2;
            end
          TOKEN:
            if (rx_d == 8'hFF && cnt_q != TOK_LAST) cnt_q <= cnt_q + 16'd1;
            else begin
              cnt_q      <= 16'd0;
              state_q    <= rx_d == 8'hFE ? DATA : TAIL;
              err_code_q <= rx_d == 8'hFE ? 2'd0 : 2'd3;
            end
          DATA: begin
            data_out_q <= rx_d;
            dv_q       <= 1'b1;
            cnt_q      <= {7'd0, cnt_q[8:0] + 9'd1};
            if (cnt_q[8:0] == 9'h1FF) state_q <= CRC;
          end
          CRC: begin
            cnt_q <= cnt_q == 16'd1 ? 16'd0 : cnt_q + 16'd1;
            if (cnt_q == 16'd1) state_q <= TAIL;
          end
          TAIL:    cnt_q <= 16'd1;
          default: ;
        endcase
      end
      if (state_q == IDLE && rd_req) begin
        addr_q     <= sdhc ? rd_lba : {rd_lba[22:0], 9'b0};
        cs_q       <= 1'b0;
        sdi_q      <= CMD17[7];
        tx_q       <= {CMD17[6:0], 1'b1};
        cnt_q      <= 16'd0;
        div_q      <= 8'd0;
        sck_q      <= 1'b0;
        bit_q      <= 3'd0;
        err_code_q <= 2'd0;
        err_q      <= 1'b0;
        busy_q     <= 1'b1;
        state_q    <= CMD;
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign data_out   = data_out_q;
  assign data_valid = dv_q;
  assign sd_cs      = cs_q;
  assign sd_sck     = sck_q;
  assign sd_sdi     = sdi_q;
endmodule

// File: tb/tb_sd_spi_block_reader.sv
// tb_sd_spi_block_reader: SD card model plus table-driven transactions and a data scoreboard.
module tb_sd_spi_block_reader;
  localparam int CLK_DIV   = 2;
  localparam int NCR_MAX   = 16;
  localparam int TOKEN_MAX = 20;

  logic        clk = 1'b0, reset_n = 1'b0, rd_req = 1'b0, sdhc = 1'b0, sd_sdo = 1'b1;
  logic [31:0] rd_lba = 32'd0;
  logic        busy, done, err, data_valid, sd_cs, sd_sck, sd_sdi;
  logic [1:0]  err_code;
  logic [7:0]  data_out;

  always #5 clk = ~clk;

  sd_spi_block_reader #(.CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX), .TOKEN_MAX(TOKEN_MAX)) dut (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .rd_lba(rd_lba), .sdhc(sdhc),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .data_out(data_out),
    .data_valid(data_valid), .sd_cs(sd_cs), .sd_sck(sd_sck), .sd_sdi(sd_sdi), .sd_sdo(sd_sdo)
  );

  typedef struct {
    logic        sdhc;
    logic [31:0] lba;
    logic [31:0] addr;
    logic        mute;
    int          rd;
    logic [7:0]  r1;
    int          td;
    logic [7:0]  tok;
    int          nbytes;
    logic [1:0]  code;
  } vec_t;

  vec_t       vecs[7];
  int         n_chk = 0, n_fail = 0, dv_cnt = 0, cs_falls = 0;
  logic [7:0] exp_q[$], mosi_q[$];

  logic       c_mute = 1'b0;
  int         c_rd = 0, c_td = 0, c_bit = 0, c_n = 0;
  logic [7:0] c_r1 = 8'h00, c_tok = 8'hFE, c_sh = 8'hFF, c_out = 8'hFF;
  logic       c_sck = 1'b0;

  logic       m_sck = 1'b0, m_cs = 1'b1, m_first = 1'b0, sck_en = 1'b0;
  int         m_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Card response to master byte n (counting from the CMD17 opcode)
  function automatic logic [7:0] card_byte(input int n);
    int r, t;
    r = 6 + c_rd;
    t = r + 1 + c_td;
    if (c_mute || n < r) return 8'hFF;
    if (n == r) return c_r1;
    if (c_r1 != 8'h00 || n < t) return 8'hFF;
    if (n == t) return c_tok;
    if (c_tok != 8'hFE || n > t + 512) return 8'hFF;
    return 8'(n - t - 1);
  endfunction

  always @(negedge clk) begin
    if (sd_sck && !c_sck) c_sh = {c_sh[6:0], sd_sdi};
    if (!sd_sck && c_sck) begin
      c_bit++;
      if (c_bit == 8) begin
        mosi_q.push_back(c_sh);
        c_n++;
        c_bit = 0;
        c_out = card_byte(c_n);
      end
    end
    if (sd_cs) begin
      c_bit = 0;
      c_n   = 0;
      c_out = card_byte(0);
    end
    c_sck  = sd_sck;
    sd_sdo = sd_cs ? 1'b1 : c_out[3'(7 - c_bit)];
  end

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dv_unexpected: data_valid with data_out=%h, no byte expected", data_out);
      end else chk("data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (m_cs && !sd_cs) begin
      cs_falls++;
      m_run   = 1;
      m_first = 1'b1;
    end else if (sd_sck != m_sck) begin
      if (sck_en && m_first) chk("sck_first_rise", 32'(m_run >= CLK_DIV), 32'd1);
      else if (sck_en) chk("sck_half", m_run, CLK_DIV);
      m_first = 1'b0;
      m_run   = 1;
    end else m_run++;
    m_cs  = sd_cs;
    m_sck = sd_sck;
  end

  task automatic start_card(input vec_t v);
    c_mute = v.mute; c_rd = v.rd; c_r1 = v.r1; c_td = v.td; c_tok = v.tok;
    sck_en = 1'b1;
    mosi_q.delete();
    if (v.code == 2'd0) for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
  endtask

  // Called at a negedge; rd_req is sampled on the next rising edge
  task automatic run_vec(input vec_t v, input string nm, input bit spam);
    int dv0, cf0, cyc, nff;
    logic [7:0] e;
    start_card(v);
    dv0 = dv_cnt;
    cf0 = cs_falls;
    rd_req = 1'b1; rd_lba = v.lba; sdhc = v.sdhc;
    @(negedge clk);
    rd_req = 1'b0; rd_lba = $urandom; sdhc = 1'($urandom);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      rd_req = spam && cyc == 40;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_done: no done within %0d cycles", nm, cyc);
    end else begin
      chk({nm, "_err"}, {31'd0, err}, {31'd0, v.code != 2'd0});
      chk({nm, "_code"}, {30'd0, err_code}, {30'd0, v.code});
      chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
      chk({nm, "_cs_done"}, {31'd0, sd_cs}, 32'd1);
      chk({nm, "_sck_done"}, {31'd0, sd_sck}, 32'd0);
    end
    rd_req = spam;
    @(negedge clk);
    rd_req = 1'b0;
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, "_err_held"}, {31'd0, err}, {31'd0, v.code != 2'd0});
    if (spam) repeat (200) @(negedge clk);
    chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({nm, "_nbytes"}, mosi_q.size(), v.nbytes);
    for (int i = 0; i < 6; i++) begin
      e = i == 0 ? 8'h51 : i == 5 ? 8'hFF : v.addr[8*(4-i) +: 8];
      chk($sformatf("%s_cmd%0d", nm, i), i < mosi_q.size() ? {24'd0, mosi_q[i]} : 32'hDEAD, {24'd0, e});
    end
    nff = 0;
    for (int i = 6; i < mosi_q.size(); i++) if (mosi_q[i] != 8'hFF) nff++;
    chk({nm, "_mosi_ff"}, nff, 0);
    chk({nm, "_nvalid"}, dv_cnt - dv0, v.code == 2'd0 ? 512 : 0);
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
    chk({nm, "_ntrans"}, cs_falls - cf0, 1);
  endtask

  initial begin
    int dv0, cyc;
    vecs[0] = '{1'b1, 32'h0000_1234, 32'h0000_1234, 1'b0, 2,  8'h00, 5,    8'hFE, 530, 2'd0};
    vecs[1] = '{1'b0, 32'h0000_0003, 32'h0000_0600, 1'b0, 1,  8'h00, 3,    8'h08, 13,  2'd3};
    vecs[2] = '{1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0,  8'h00, 0,    8'hFE, 23,  2'd1};
    vecs[3] = '{1'b1, 32'hA5C3_0F96, 32'hA5C3_0F96, 1'b0, 0,  8'h04, 0,    8'hFE, 8,   2'd2};
    vecs[4] = '{1'b0, 32'h00FF_FFFF, 32'hFFFF_FE00, 1'b0, 0,  8'h00, 1000, 8'hFF, 28,  2'd3};
    vecs[5] = '{1'b0, 32'h8000_0001, 32'h0000_0200, 1'b0, 15, 8'h00, 19,   8'hFE, 557, 2'd0};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 16, 8'h00, 0,    8'hFE, 23,  2'd1};

    repeat (3) @(negedge clk);
    chk("rst_cs", {31'd0, sd_cs}, 32'd1);
    chk("rst_sck", {31'd0, sd_sck}, 32'd0);
    chk("rst_sdi", {31'd0, sd_sdi}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {29'd0, err, err_code}, 32'd0);
    chk("rst_data", {23'd0, data_valid, data_out}, 32'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i), 1'b0);

    start_card(vecs[0]);
    dv0 = dv_cnt;
    rd_req = 1'b1; rd_lba = vecs[0].lba; sdhc = vecs[0].sdhc;
    @(negedge clk);
    rd_req = 1'b0;
    cyc = 0;
    while (dv_cnt - dv0 < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reached", dv_cnt - dv0, 200);
    sck_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_cs", {31'd0, sd_cs}, 32'd1);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_sck", {31'd0, sd_sck}, 32'd0);
    chk("mid_outs", {22'd0, err, err_code, data_valid, data_out}, 32'd0);
    exp_q.delete();
    dv0 = dv_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid_no_dv", dv_cnt - dv0, 0);
    run_vec(vecs[0], "after_rst", 1'b0);

    run_vec(vecs[3], "spam", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
